// File: rtl/reg_bank_arbiter_if.sv
// Write-port bundle between four requesters and the shared register bank.
// Requesters drive the master side; the arbiter owns grants and register contents.
interface reg_bank_arbiter_if #(
  parameter int N = 4
) ();
  logic [3:0]     req;
  logic [7:0]     addr;
  logic [4*N-1:0] wdata;
  logic [3:0]     gnt;
  logic [1:0]     gnt_id;
  logic [4*N-1:0] q;

  modport master (
    output req, addr, wdata,
    input  gnt, gnt_id, q
  );

  modport slave (
    input  req, addr, wdata,
    output gnt, gnt_id, q
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter over four N-bit registers; grant and write land on the same edge (1 cycle).
// No stall path: losers keep req asserted; a requester granted last cycle sits out one cycle.
module reg_bank_arbiter #(
  parameter int N = 4
) (
  input logic              clk,
  input logic              reset,
  reg_bank_arbiter_if.slave bus
);

  logic [1:0]        ptr;
  logic [3:0]        gnt_r;
  logic [1:0]        gnt_id_r;
  logic [3:0][N-1:0] regs;

  logic [3:0]   eligible;
  logic         have_win;
  logic [1:0]   win;
  logic [1:0]   scan_idx;
  logic [1:0]   win_addr;
  logic [N-1:0] win_data;

  // Holding gnt for one cycle is what blocks back-to-back grants to one requester.
  assign eligible = bus.req & ~gnt_r;

  always_comb begin
    have_win = 1'b0;
    win      = ptr;
    scan_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!have_win && eligible[scan_idx]) begin
        have_win = 1'b1;
        win      = scan_idx;
      end
    end
  end

  assign win_addr = bus.addr[2*win +: 2];
  assign win_data = bus.wdata[N*win +: N];

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r    <= '0;
      gnt_id_r <= '0;
      ptr      <= '0;
      regs     <= '0;
    end else if (have_win) begin
      gnt_r          <= 4'b0001 << win;
      gnt_id_r       <= win;
      ptr            <= win + 2'd1;
      regs[win_addr] <= win_data;
    end else begin
      gnt_r <= '0;
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.gnt_id = gnt_id_r;
  assign bus.q      = regs;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench: stimulus pushes the model's expected post-edge state; a monitor pops and compares.
module tb_reg_bank_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.N(N)) bus ();
  reg_bank_arbiter #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]     gnt;
    logic [1:0]     gnt_id;
    logic [4*N-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register array, priority start, last granted requester (-1 = none)
  logic [N-1:0] m_reg[4];
  int m_ptr  = 0;
  int m_last = -1;
  int m_id   = 0;

  function automatic void model_step(input bit rst, input logic [3:0] rq,
                                     input logic [7:0] ad, input logic [4*N-1:0] wd);
    exp_t e;
    int w;
    logic [1:0] ta;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_ptr  = 0;
      m_last = -1;
      m_id   = 0;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (w < 0 && rq[j] && j != m_last) w = j;
      end
      if (w >= 0) begin
        ta = ad[2*w +: 2];
        m_reg[ta] = wd[N*w +: N];
        m_id  = w;
        m_ptr = (w + 1) % 4;
      end
      m_last = w;
    end
    e.gnt    = (m_last < 0) ? 4'b0000 : (4'b0001 << m_last);
    e.gnt_id = 2'(m_id);
    e.q      = '0;
    for (int k = 0; k < 4; k++) e.q[N*k +: N] = m_reg[k];
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input bit rst, input logic [3:0] rq,
                     input logic [7:0] ad, input logic [4*N-1:0] wd);
    @(negedge clk);
    reset     = rst;
    bus.req   = rq;
    bus.addr  = ad;
    bus.wdata = wd;
    model_step(rst, rq, ad, wd);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: each entry describes DUT state just after the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("gnt_id", 32'(bus.gnt_id), 32'(e.gnt_id));
        for (int k = 0; k < 4; k++)
          chk($sformatf("q%0d", k), 32'(bus.q[N*k +: N]), 32'(e.q[N*k +: N]));
      end
    end
  end

  localparam logic [7:0]     RR_ADDR = 8'hE4;    // requester i -> register i
  localparam logic [4*N-1:0] RR_DATA = 16'h4321; // requester i writes i+1

  initial begin
    bus.req   = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset held with every requester asking
    cyc(1'b1, 4'b1111, 8'($urandom), 16'($urandom));
    cyc(1'b1, 4'b1111, 8'($urandom), 16'($urandom));
    // Round robin from requester 0
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, RR_ADDR, RR_DATA);

    // Single write: requester 2 -> register 3 = A
    cyc(1'b1, 4'b0000, 8'h00, 16'h0000);
    cyc(1'b0, 4'b0100, 8'h30, 16'h0A00);
    cyc(1'b0, 4'b0000, 8'h30, 16'h0A00);
    cyc(1'b0, 4'b0000, 8'h00, 16'h0000);

    // Lone requester 1 held high: alternating grants
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0010, 8'($urandom), 16'($urandom));

    // Collision on register 2: requester 0 writes 5, then requester 3 writes 9
    cyc(1'b1, 4'b0000, 8'h00, 16'h0000);
    cyc(1'b0, 4'b1001, 8'h82, 16'h9005);
    cyc(1'b0, 4'b1000, 8'h82, 16'h9005);
    cyc(1'b0, 4'b0000, 8'h82, 16'h9005);

    // Reset mid round robin
    for (int i = 0; i < 2; i++) cyc(1'b0, 4'b1111, RR_ADDR, RR_DATA);
    cyc(1'b1, 4'b1111, RR_ADDR, RR_DATA);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, RR_ADDR, RR_DATA);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 39) == 0), 4'($urandom), 8'($urandom), 16'($urandom));
    cyc(1'b0, 4'b0000, 8'h00, 16'h0000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter that shares a bank of four N-bit registers among four requesters. Each cycle at most one pending write request wins, and the winning data is loaded into the addressed register at the same clock edge that raises that requester's grant. The block sits between independent datapath producers and the shared register bank, and is the single point of write access to those registers.

## Interface
- N, default 4: data width of each register and of each requester's write data.
- clk  input  1  rising-edge clock; all state changes on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- req  input  4  req[i] high = requester i has a pending write.
- addr  input  8  addr[2i+1:2i] = target register (0..3) for requester i.
- wdata  input  4N  wdata[N*i+N-1:N*i] = write data for requester i.
- gnt  output  4  registered one-hot grant, or all zero.
- gnt_id  output  2  index of the requester granted in the current gnt cycle; holds its last value when gnt is 0.
- q  output  4N  q[N*k+N-1:N*k] = contents of register k.

## Operation
- State:
  - 2-bit priority pointer ptr.
  - gnt register.
  - gnt_id register.
  - Four N-bit storage registers.
- Eligibility: requester i is eligible in a cycle when req[i] = 1 and gnt[i] = 0. A requester is never granted in two consecutive cycles.
- Winner selection: the first eligible index found scanning ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- At a posedge with a winner w:
  - gnt <= one-hot(w).
  - gnt_id <= w.
  - Register addr_w <= wdata_w.
  - ptr <= w+1 mod 4 (wraps 3 -> 0).
- At a posedge with no winner:
  - gnt <= 0.
  - ptr and registers unchanged.
  - gnt_id holds.
- Handshake:
  - A requester holds req, addr and wdata stable until it sees gnt[i] = 1.
  - The write has already happened when gnt[i] is visible.
  - The requester may drop req in the gnt cycle, or keep it high to issue a new write. Any new write is granted no earlier than two cycles after the previous grant.
- Registers not addressed by the winner retain their value. Exactly one register is written per grant.
- Reset:
  - q = 0 for all registers.
  - gnt = 0.
  - gnt_id = 0.
  - ptr = 0, so requester 0 has highest priority.
  - Reset wins over any request in the same cycle: no write and no grant occur.
  - Reset asserted mid-stream discards the pending requests. Requesters still holding req are arbitrated normally from ptr = 0 in the first cycle after reset deasserts.

## Timing
- Latency: req sampled at edge t produces gnt and the register update after edge t, visible in cycle t+1. The new q value is visible in the same cycle as gnt.
- q is purely registered; there is no combinational path from req, addr or wdata to any output.
- Throughput: one write per cycle aggregate. Per requester, at most one write every 2 cycles.
- Fairness: with all four requesters continuously asserting, grants rotate 0,1,2,3,0,... Any requester waits at most 4 cycles from asserting req to receiving gnt.
- Two requesters may target the same register. Writes apply in grant order, and the later grant's data is what remains.
- Inputs of non-winning requesters are ignored. Changing them has no effect on state.

## Test plan
- **Reset.** Drive reset for 2 cycles with all req = 4'b1111.
  - Required: gnt = 0, gnt_id = 0 and q = 0 throughout.
  - Required: the first grant after release goes to requester 0.
- **Single write** (N=4). req = 4'b0100, addr for requester 2 = 3, wdata for requester 2 = 4'hA for one edge.
  - Required: next cycle gnt = 4'b0100, gnt_id = 2, register 3 = 4'hA, other registers 0.
  - Required: following cycle gnt = 0.
- **Round-robin.** All four req held high, requester i writes value i+1 to register i.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
  - Required: after 4 grants q registers = 1, 2, 3, 4.
- **No back-to-back.** Only requester 1 holds req high for 6 cycles.
  - Required: gnt alternates 0010, 0000, 0010, ... and a write occurs only in the grant cycles.
- **Same-register collision.** Requesters 0 and 3 both target register 2, with data 4'h5 and 4'h9, ptr = 0, each dropping req on its grant.
  - Required: requester 0 is granted first, then requester 3.
  - Required: final register 2 = 4'h9.
- **Reset mid-operation.** Assert reset during cycle 2 of the round-robin scenario.
  - Required: all registers and gnt clear the following cycle.
  - Required: after release, arbitration restarts at requester 0.
